// File: rtl/mux_row_sequencer.sv
// Scan sequencer between the multiplexing LUT and the driver serializer.
// Optional build macro MUX_SCAN_STATS_EN adds the stall_cnt statistics output.
`timescale 1ns/1ps
module mux_row_sequencer #(
  parameter int NB_LEDS_PER_GROUP = 16,
  parameter int NB_LED_ROWS       = 32,
  parameter int DATA_WIDTH        = 16,
  parameter int BLANK_CYCLES      = 8,
  localparam int LED_WIDTH        = $clog2(NB_LEDS_PER_GROUP),
  localparam int LED_ROW_WIDTH    = $clog2(NB_LED_ROWS)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     enable,
  output logic [3:0]               ld_row_en,
  output logic [LED_WIDTH-1:0]     led,
  input  logic [LED_ROW_WIDTH-1:0] led_row,
  output logic                     ram_rd_en,
  output logic [LED_ROW_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     latch,
  output logic                     blank,
  output logic [3:0]               row_en,
  output logic                     frame_done
`ifdef MUX_SCAN_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int BCNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BCNT_W-1:0]    BCNT_LAST = BCNT_W'(BLANK_CYCLES - 1);
  localparam logic [LED_WIDTH-1:0] LED_LAST  = LED_WIDTH'(NB_LEDS_PER_GROUP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_RD, S_FETCH_CAP, S_SEND, S_LATCH, S_BLANK, S_SWAP
  } state_t;

  state_t              state, next_state;
  logic [BCNT_W-1:0]   blank_cnt, blank_cnt_d;
  logic [LED_WIDTH-1:0] led_d;
  logic [3:0]          ld_row_en_d, row_en_d;
  logic                blank_d, pix_valid_d, latch_d, frame_done_d, cap;
  logic                xfer;

  assign xfer     = (state == S_SEND) && pix_valid && pix_ready;
  assign ram_addr = led_row;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (enable) next_state = S_FETCH_RD;
      S_FETCH_RD:  next_state = S_FETCH_CAP;
      S_FETCH_CAP: next_state = S_SEND;
      S_SEND:      if (xfer) next_state = (led == LED_LAST) ? S_LATCH : S_FETCH_RD;
      S_LATCH:     next_state = S_BLANK;
      S_BLANK:     if (blank_cnt == BCNT_LAST) next_state = S_SWAP;
      S_SWAP:      next_state = enable ? S_FETCH_RD : S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; ram_rd_en is decoded directly.
  always_comb begin
    ram_rd_en    = (state == S_FETCH_RD);
    led_d        = led;
    ld_row_en_d  = ld_row_en;
    row_en_d     = row_en;
    blank_d      = blank;
    pix_valid_d  = pix_valid;
    latch_d      = 1'b0;
    frame_done_d = 1'b0;
    blank_cnt_d  = blank_cnt;
    cap          = 1'b0;
    case (state)
      S_IDLE: begin
        row_en_d = 4'b0000;
        blank_d  = 1'b1;
      end
      S_FETCH_CAP: begin
        cap         = 1'b1;
        pix_valid_d = 1'b1;
      end
      S_SEND: begin
        if (xfer) begin
          pix_valid_d = 1'b0;
          if (led == LED_LAST) begin
            led_d   = '0;
            latch_d = 1'b1;
            blank_d = 1'b1;
          end else begin
            led_d = led + LED_WIDTH'(1);
          end
        end
      end
      S_LATCH: blank_cnt_d = '0;
      S_BLANK: blank_cnt_d = blank_cnt + BCNT_W'(1);
      S_SWAP: begin
        row_en_d     = ld_row_en;
        ld_row_en_d  = {ld_row_en[2:0], ld_row_en[3]};
        frame_done_d = (ld_row_en == 4'b1000);
        blank_d      = !enable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      led        <= '0;
      ld_row_en  <= 4'b0001;
      row_en     <= 4'b0000;
      blank      <= 1'b1;
      pix_valid  <= 1'b0;
      latch      <= 1'b0;
      frame_done <= 1'b0;
      blank_cnt  <= '0;
    end else begin
      led        <= led_d;
      ld_row_en  <= ld_row_en_d;
      row_en     <= row_en_d;
      blank      <= blank_d;
      pix_valid  <= pix_valid_d;
      latch      <= latch_d;
      frame_done <= frame_done_d;
      blank_cnt  <= blank_cnt_d;
    end
  end

  // Pixel data path: qualified by pix_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (cap) pix_data <= ram_rdata;
  end

`ifdef MUX_SCAN_STATS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      stall_cnt <= '0;
    else if (frame_done)
      stall_cnt <= '0;
    else if (pix_valid && !pix_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_row_sequencer.sv
// Randomized bench for mux_row_sequencer with a scoreboard of expected
// addresses, pixels, latch spacing and row swaps.
`timescale 1ns/1ps
module tb_mux_row_sequencer;
  logic        clk = 1'b0;
  logic        nrst, enable, pix_ready;
  logic [3:0]  ld_row_en, row_en;
  logic [3:0]  led;
  logic [4:0]  led_row, ram_addr;
  logic        ram_rd_en, pix_valid, latch, blank, frame_done;
  logic [15:0] ram_rdata, pix_data;
`ifdef MUX_SCAN_STATS_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  mux_row_sequencer dut (
    .clk(clk), .nrst(nrst), .enable(enable),
    .ld_row_en(ld_row_en), .led(led), .led_row(led_row),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .latch(latch), .blank(blank), .row_en(row_en), .frame_done(frame_done)
`ifdef MUX_SCAN_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // LUT: rows 0/2 address the lower half of the column, rows 1/3 the upper half.
  always_comb begin
    led_row = {1'b0, led};
    if (ld_row_en[1] || ld_row_en[3]) led_row = {1'b1, led};
  end

  logic [15:0] mem [32];
  always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state, owned by the monitor only.
  bit          mon_on = 1'b0;
  int          cyc = 0, last_latch, stall_since, latches, chk_cyc, chk_row;
  int          rd_k, xf_k;
  bit          cont, swap_en, first_swap, prev_stall;
  logic [15:0] prev_data, m_stall;
  logic [15:0] pq [$];

  always @(negedge clk) begin
    cyc++;
    if (!mon_on) begin
      last_latch = -1; stall_since = 0; latches = 0; chk_cyc = -100; chk_row = 0;
      rd_k = 0; xf_k = 0; cont = 0; swap_en = 0; first_swap = 0; prev_stall = 0;
      m_stall = 0; pq.delete();
    end else begin
      if (ram_rd_en) begin
        check("rd_while_valid", pix_valid, 0);
        check("ram_addr", ram_addr, ((rd_k / 16) % 2) * 16 + rd_k % 16);
        pq.push_back(mem[ram_addr]);
        rd_k++;
      end
      if (pix_valid && pix_ready) begin
        if (pq.size() == 0) check("xfer_without_read", 1, 0);
        else check("pix_data", pix_data, pq.pop_front());
        xf_k++;
      end
      if (prev_stall) begin
        check("stall_hold_valid", pix_valid, 1);
        check("stall_hold_data", pix_data, prev_data);
      end
      if (pix_valid && !pix_ready) stall_since++;
      if (latch) begin
        check("latch_xfers", xf_k, (latches + 1) * 16);
        if (last_latch >= 0 && cont) check("latch_gap", cyc - last_latch, 58 + stall_since);
        last_latch = cyc; stall_since = 0; cont = 1;
        chk_cyc = cyc + 10; chk_row = latches % 4; latches++;
      end
      if (cyc == chk_cyc - 1) begin
        swap_en = enable;
        check("blank_in_swap", blank, 1);
      end
      if (cyc == chk_cyc) begin
        check("row_en_after_swap", row_en, 1 << chk_row);
        check("blank_after_swap", blank, !swap_en);
        if (!swap_en) cont = 0;
        first_swap = 1;
      end
      if (cyc == chk_cyc + 1 && !swap_en) check("row_en_idle", row_en, 0);
      if (!first_swap) begin
        check("blank_pre_swap", blank, 1);
        check("row_en_pre_swap", row_en, 0);
      end
      check("frame_done", frame_done, (cyc == chk_cyc && chk_row == 3) ? 1 : 0);
`ifdef MUX_SCAN_STATS_EN
      check("stall_cnt", stall_cnt, m_stall);
      if (frame_done) m_stall = 0;
      else if (pix_valid && !pix_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
    end
  end

  task automatic wait_latches(input int n);
    int target = latches + n;
    int cnt = 0;
    while (latches < target && cnt < 200 * n) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    if (latches < target) check("wait_latch_timeout", latches, target);
  endtask

  initial begin
    int  cnt;
    bit  hit;
    for (int i = 0; i < 32; i++) mem[i] = 16'(i * 3);
    nrst = 1'b0; enable = 1'b0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ld_row_en", ld_row_en, 4'b0001);
    check("rst_led", led, 0);
    check("rst_row_en", row_en, 0);
    check("rst_blank", blank, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_latch", latch, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ram_rd_en", ram_rd_en, 0);
    nrst = 1'b1; mon_on = 1'b1; enable = 1'b1;

    // Two full frames with the serializer always ready.
    wait_latches(8);

    // Backpressure: hold ready low for 5 cycles while led 7 is offered.
    hit = 0; cnt = 0;
    while (!hit && cnt < 200) begin
      @(posedge clk); #1; cnt++;
      hit = (led == 4'd7) && pix_valid;
    end
    check("bp_found_led7", hit, 1);
    pix_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("bp_pix_valid_held", pix_valid, 1);
    check("bp_led_held", led, 7);
`ifdef MUX_SCAN_STATS_EN
    check("stall_cnt_bp", stall_cnt, 5);
`endif
    pix_ready = 1'b1;
    wait_latches(1);

    // Random pixel contents and random serializer backpressure.
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      pix_ready = ($urandom_range(3) != 0);
    end
    pix_ready = 1'b1;

    // Drop enable while loading led 4 of row 1.
    hit = 0; cnt = 0;
    while (!hit && cnt < 400) begin
      @(posedge clk); #1; cnt++;
      hit = (ld_row_en == 4'b0010) && (led == 4'd4);
    end
    check("drop_found_row1", hit, 1);
    enable = 1'b0;
    wait_latches(1);
    repeat (15) @(posedge clk);
    #1;
    check("idle_ld_row_en", ld_row_en, 4'b0100);
    check("idle_led", led, 0);
    check("idle_row_en", row_en, 0);
    check("idle_blank", blank, 1);
    check("idle_no_read", ram_rd_en, 0);
    check("idle_no_valid", pix_valid, 0);
    enable = 1'b1;
    wait_latches(2);

    // Asynchronous reset in the middle of SEND.
    pix_ready = 1'b0;
    hit = 0; cnt = 0;
    while (!hit && cnt < 200) begin
      @(posedge clk); #1; cnt++;
      hit = pix_valid;
    end
    check("arst_found_send", hit, 1);
    #1;
    nrst = 1'b0; mon_on = 1'b0;
    #1;
    check("arst_row_en", row_en, 0);
    check("arst_blank", blank, 1);
    check("arst_pix_valid", pix_valid, 0);
    check("arst_latch", latch, 0);
    check("arst_ld_row_en", ld_row_en, 4'b0001);
    check("arst_led", led, 0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1; pix_ready = 1'b1; mon_on = 1'b1;
    wait_latches(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
